// File: rtl/strm_serial_host.sv
// strm_serial_host: turns byte commands into the stream memory's bit-serial pin sequence.
// Optional mode-configure op is built only when STRM_HOST_CFG_EN is defined.
module strm_serial_host #(
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       strm_din,
  output logic       strm_hold,
  output logic       strm_write,
  output logic       strm_config,
  output logic [1:0] strm_mode,
  input  logic       strm_dout
);

  localparam int unsigned PW = 4;
  localparam int unsigned BW = 3;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
`ifdef STRM_HOST_CFG_EN
  localparam logic [1:0] OP_CONFIG = 2'b10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    COMMIT,
    RECOVER,
    POP,
    CAPTURE,
`ifdef STRM_HOST_CFG_EN
    CONFIG,
`endif
    RESP
  } state_t;

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [BW-1:0]   bcnt;
  logic [7:0]      shreg;
  logic            period_last;

  assign period_last = (pcnt == PW'(BIT_CYCLES - 1));

`ifndef STRM_HOST_CFG_EN
  assign strm_config = 1'b0;
  assign strm_mode   = 2'b00;
`endif

  // Sequencer: every phase lasts a whole number of BIT_CYCLES-long periods.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      strm_din   <= 1'b0;
      strm_hold  <= 1'b1;
      strm_write <= 1'b0;
`ifdef STRM_HOST_CFG_EN
      strm_config <= 1'b0;
      strm_mode   <= 2'b00;
`endif
    end else begin
      if (state != IDLE && state != RESP) begin
        pcnt <= period_last ? '0 : pcnt + PW'(1);
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            pcnt      <= '0;
            bcnt      <= '0;
            shreg     <= cmd_data;
            case (cmd_op)
              OP_WRITE: begin
                state    <= SHIFT;
                strm_din <= cmd_data[7];
              end
              OP_READ: begin
                state     <= POP;
                strm_hold <= 1'b0;
              end
`ifdef STRM_HOST_CFG_EN
              OP_CONFIG: begin
                state       <= CONFIG;
                strm_config <= 1'b1;
                strm_mode   <= cmd_data[1:0];
              end
`endif
              default: begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        SHIFT: begin
          if (period_last) begin
            if (bcnt == BW'(7)) begin
              state      <= COMMIT;
              strm_din   <= 1'b0;
              strm_hold  <= 1'b0;
              strm_write <= 1'b1;
            end else begin
              bcnt     <= bcnt + BW'(1);
              strm_din <= shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
            end
          end
        end

        COMMIT: begin
          if (period_last) begin
            state      <= RECOVER;
            strm_write <= 1'b0;
            strm_hold  <= 1'b1;
          end
        end

        RECOVER: begin
          if (period_last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end

        POP: begin
          if (period_last) begin
            state     <= CAPTURE;
            strm_hold <= 1'b1;
          end
        end

        // Memory data is taken on the last cycle of each period, MSB first.
        CAPTURE: begin
          if (period_last) begin
            shreg <= {shreg[6:0], strm_dout};
            if (bcnt == BW'(7)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= {shreg[6:0], strm_dout};
              rsp_err   <= 1'b0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end

`ifdef STRM_HOST_CFG_EN
        CONFIG: begin
          if (period_last) begin
            if (bcnt == BW'(3)) begin
              state       <= RESP;
              strm_config <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_data    <= '0;
              rsp_err     <= 1'b0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
`endif

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strm_serial_host.sv
// Self-checking bench for strm_serial_host: directed vector table, hand-written
// reset/stall sequences, and randomized commands against a cycle-schedule model.
module tb_strm_serial_host;

  localparam int B = 2;
`ifdef STRM_HOST_CFG_EN
  localparam bit CFG     = 1'b1;
  localparam int CFG_LAT = 9;
  localparam bit CFG_ERR = 1'b0;
`else
  localparam bit CFG     = 1'b0;
  localparam int CFG_LAT = 1;
  localparam bit CFG_ERR = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       strm_din;
  logic       strm_hold;
  logic       strm_write;
  logic       strm_config;
  logic [1:0] strm_mode;
  logic       strm_dout = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_byte = 8'h00;
  logic [1:0] cur_mode = 2'b00;

  strm_serial_host #(.BIT_CYCLES(B)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .strm_din(strm_din), .strm_hold(strm_hold), .strm_write(strm_write),
    .strm_config(strm_config), .strm_mode(strm_mode), .strm_dout(strm_dout)
  );

  always #5 clk = ~clk;

  // Memory model: after a pop (hold low then high) it presents one byte MSB first,
  // one bit per B cycles; otherwise the data line carries noise.
  logic prev_hold = 1'b1;
  bit   mem_active = 1'b0;
  int   cap_cnt = 0;
  int   mem_idx;
  always @(negedge clk) begin
    if (prev_hold === 1'b0 && strm_hold === 1'b1) begin
      mem_active = 1'b1;
      cap_cnt = 0;
    end
    if (mem_active) begin
      mem_idx = 7 - cap_cnt / B;
      strm_dout = mem_byte[mem_idx[2:0]];
      cap_cnt++;
      if (cap_cnt >= 8 * B) mem_active = 1'b0;
    end else begin
      strm_dout = 1'($urandom_range(0, 1));
    end
    prev_hold = strm_hold;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pins();
    return {strm_din, strm_hold, strm_write, strm_config, strm_mode};
  endfunction

  // Expected pin word {din, hold, write, config, mode} on cycle n after acceptance.
  function automatic logic [5:0] exp_pins(input logic [1:0] op, input logic [7:0] data, input int n);
    logic din, hold, wr, cf;
    logic [1:0] md;
    int idx;
    din = 1'b0; hold = 1'b1; wr = 1'b0; cf = 1'b0; md = cur_mode;
    case (op)
      2'd0: begin
        if (n <= 8 * B) begin
          idx = 7 - (n - 1) / B;
          din = data[idx[2:0]];
        end else if (n <= 9 * B) begin
          wr = 1'b1;
          hold = 1'b0;
        end
      end
      2'd1: if (n <= B) hold = 1'b0;
      2'd2: begin
        if (CFG) begin
          md = data[1:0];
          if (n <= 4 * B) cf = 1'b1;
        end
      end
      default: ;
    endcase
    return {din, hold, wr, cf, md};
  endfunction

  function automatic int model_lat(input logic [1:0] op);
    case (op)
      2'd0: return 10 * B + 1;
      2'd1: return 9 * B + 1;
      2'd2: return CFG ? 4 * B + 1 : 1;
      default: return 1;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] op);
    return (op == 2'd3) || (op == 2'd2 && !CFG);
  endfunction

  function automatic logic [7:0] model_rdata(input logic [1:0] op, input logic [7:0] mem);
    return (op == 2'd1) ? mem : 8'h00;
  endfunction

  task automatic chk_reset(input string name);
    chk(name,
        {16'h0, cmd_ready, rsp_valid, rsp_data, rsp_err, busy, strm_din, strm_hold,
         strm_write, strm_config, strm_mode},
        {16'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
  endtask

  // Issue one command from IDLE at a negedge, follow its pin schedule, then
  // optionally stall the response before the handshake.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] mem, input int stall, input int lat,
                        input logic [7:0] edata, input logic eerr);
    int n;
    int pin_bad;
    int stall_bad;
    mem_byte = mem;
    chk({name, " cmd_ready before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = 8'($urandom);
    n = 1;
    pin_bad = 0;
    while (rsp_valid !== 1'b1 && n <= 12 * B) begin
      if (pins() !== exp_pins(op, data, n) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        if (pin_bad == 0)
          $display("  pin detail %s: cycle %0d got %b want %b busy %b", name, n, pins(),
                   exp_pins(op, data, n), busy);
        pin_bad++;
      end
      @(negedge clk);
      n++;
    end
    if (pins() !== exp_pins(op, data, n)) pin_bad++;
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " pin schedule errors"}, 32'(pin_bad), 32'd0);
    chk({name, " rsp_data"}, 32'(rsp_data), 32'(edata));
    chk({name, " rsp_err"}, 32'(rsp_err), 32'(eerr));
    chk({name, " busy/cmd_ready in resp"}, {30'd0, busy, cmd_ready}, 32'b10);
    stall_bad = 0;
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom);
      cmd_data = 8'($urandom);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== edata || rsp_err !== eerr || cmd_ready !== 1'b0 ||
          pins() !== exp_pins(op, data, 1000))
        stall_bad++;
    end
    cmd_valid = 1'b0;
    if (stall > 0) chk({name, " stall hold errors"}, 32'(stall_bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, " after handshake"}, {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
    if (op == 2'd2 && CFG) cur_mode = data[1:0];
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] mem;
    int         stall;
    int         lat;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_bad;
    logic [1:0] op;
    logic [7:0] d, m;

    tbl.push_back('{"write AA",    2'd0, 8'hAA, 8'h00, 0, 21,      8'h00, 1'b0});
    tbl.push_back('{"read DE",     2'd1, 8'h33, 8'hDE, 0, 19,      8'hDE, 1'b0});
    tbl.push_back('{"config 01",   2'd2, 8'h01, 8'h00, 0, CFG_LAT, 8'h00, CFG_ERR});
    tbl.push_back('{"write 00",    2'd0, 8'h00, 8'h00, 1, 21,      8'h00, 1'b0});
    tbl.push_back('{"reserved",    2'd3, 8'h77, 8'h00, 2, 1,       8'h00, 1'b1});
    tbl.push_back('{"read 5A stl", 2'd1, 8'h00, 8'h5A, 5, 19,      8'h5A, 1'b0});
    tbl.push_back('{"write FF",    2'd0, 8'hFF, 8'h00, 0, 21,      8'h00, 1'b0});
    tbl.push_back('{"read 00",     2'd1, 8'hFF, 8'h00, 0, 19,      8'h00, 1'b0});
    tbl.push_back('{"read FF",     2'd1, 8'h00, 8'hFF, 0, 19,      8'hFF, 1'b0});
    tbl.push_back('{"config 10",   2'd2, 8'hFE, 8'h00, 3, CFG_LAT, 8'h00, CFG_ERR});
    tbl.push_back('{"read A5",     2'd1, 8'h12, 8'hA5, 2, 19,      8'hA5, 1'b0});

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset values");
    reset = 1'b0;
    @(negedge clk);
    chk_reset("idle after release");

    foreach (tbl[i])
      do_cmd(tbl[i].name, tbl[i].op, tbl[i].data, tbl[i].mem, tbl[i].stall,
             tbl[i].lat, tbl[i].rdata, tbl[i].err);

    // Reset while shifting bit 3 of 0xF0: everything drops asynchronously.
    mem_byte = 8'h00;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_data = 8'hF0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid-write bit3 din", 32'({strm_din, strm_hold, busy}), 32'b111);
    reset = 1'b1;
    cur_mode = 2'b00;
    #1;
    chk_reset("async reset mid-write");
    @(negedge clk);
    reset = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) n_bad++;
    end
    chk("no response after reset", 32'(n_bad), 32'd0);
    do_cmd("write 0F after reset", 2'd0, 8'h0F, 8'h00, 0, 21, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      m = 8'($urandom);
      do_cmd($sformatf("rand%0d op%0d", i, op), op, d, m, $urandom_range(0, 3),
             model_lat(op), model_rdata(op, m), model_err(op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/strm_serial_host.md
# strm_serial_host

Host-side sequencer that drives the stream memory's serial port. It turns byte-level commands (write, read, mode-configure) taken over a valid/ready handshake into the bit-serial pin sequence the stream memory expects: data bit, hold, write strobe, config strobe and mode. It returns read bytes and completion acks over a response handshake. It sits directly upstream of the stream memory's io_in pins and consumes its io_out[0] serial output.

## Interface
- BIT_CYCLES, 2: clk cycles each serial bit/strobe phase is held; legal range 1..15.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 write, 01 read, 10 config, 11 reserved.
- cmd_data  in  8  write byte; for config, bits [1:0] are the mode.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  read byte; 0x00 for write, config and error.
- rsp_err  out  1  command rejected.
- busy  out  1  high whenever state is not IDLE.
- strm_din  out  1  serial data to memory, MSB first.
- strm_hold  out  1  memory hold (low = commit/pop phase).
- strm_write  out  1  write strobe.
- strm_config  out  1  config strobe.
- strm_mode  out  2  mode value presented during config; retains the last programmed value.
- strm_dout  in  1  serial data from memory.

## Operation
- States: IDLE, SHIFT, COMMIT, RECOVER, POP, CAPTURE, CONFIG, RESP.
- A command is accepted on the rising edge where cmd_valid & cmd_ready. cmd_op and cmd_data are registered at that edge.
- Write: IDLE -> SHIFT (8 bit periods, strm_din = byte[7..0], strm_hold=1) -> COMMIT (1 period, strm_write=1, strm_hold=0) -> RECOVER (1 period, strm_write=0, strm_hold=1) -> RESP.
- Read: IDLE -> POP (1 period, strm_hold=0, strm_write=0) -> CAPTURE (8 periods, strm_hold=1).
  - strm_dout is sampled on the last cycle of each period and shifted in MSB first.
  - -> RESP with rsp_data = captured byte.
- Config: IDLE -> CONFIG (4 periods, strm_config=1, strm_mode=cmd_data[1:0]) -> RESP.
- Reserved op 11: IDLE -> RESP directly, rsp_err=1.
- RESP: rsp_valid=1 until the rising edge with rsp_ready=1, then -> IDLE. rsp_data and rsp_err are stable while rsp_valid=1.
- An empty memory is not detected; a read of an empty memory returns whatever strm_dout shows.
- Outside active phases: strm_din=0, strm_write=0, strm_config=0, strm_hold=1.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0x00, rsp_err=0, busy=0, strm_din=0, strm_hold=1, strm_write=0, strm_config=0, strm_mode=00, state=IDLE, bit/period counters=0.
- All strm_* outputs are registered. They change on the first edge after acceptance.
- Let B = BIT_CYCLES.
  - Write: 10B cycles of pin activity, then rsp_valid.
  - Read: 9B cycles, then rsp_valid.
  - Config: 4B cycles, then rsp_valid.
  - Reserved: rsp_valid on the cycle after acceptance.
- Back-to-back: the earliest next acceptance is the cycle after the rsp handshake.
- Period counter wraps from B-1 to 0. The bit counter advances on the wrap and ends at 7.
- Reset asserted mid-operation: all outputs return to reset values immediately and asynchronously. The partial byte is discarded and no response is issued.
- cmd_valid while busy: ignored, no side effect.

## Configuration
- Macro STRM_HOST_CFG_EN.
- Defined: config op is implemented as described.
- Undefined: CONFIG state is absent, and op 10 is handled like reserved (rsp_err=1, no pin activity). strm_config is tied to 0 and strm_mode is tied to 00.

## Test plan
- B=2, write 0xAA -> strm_din 1,0,1,0,1,0,1,0, each held 2 cycles. strm_write=1 and strm_hold=0 on cycles 17-18 after acceptance. rsp_valid on cycle 21 with rsp_data=0x00, rsp_err=0.
- B=2, read with the memory model serialising 0xDE -> strm_hold low for 2 cycles, then rsp_data=0xDE, rsp_err=0.
- Config mode 01 -> strm_config high for 8 cycles with strm_mode=01. strm_mode stays 01 afterwards. With the macro undefined -> rsp_err=1 and strm_config never rises.
- Reserved op 11 -> rsp_err=1, rsp_data=0x00, no strm_* toggling.
- rsp_ready held low 5 cycles after read of 0x5A -> rsp_valid and rsp_data=0x5A hold, cmd_ready=0, and a concurrent cmd_valid is ignored.
- Reset asserted during SHIFT bit 3 of write 0xF0 -> all outputs at reset values the same cycle, no response. A following write of 0x0F completes normally.
